// File: rtl/arbitro_2a1.sv
// Two-requester round-robin arbiter driving a shared mux select and memory request.
// Optional watchdog abort on a stalled resource, compiled in with `define ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction; arbitrate Req0/Req1 on each edge
// ACTIVE | MemReq high, Selector frozen, waiting for MemReady
// DONE   | one-cycle Ack (or Error) pulse, requests ignored

module arbitro_2a1 #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic Req0,
    input  logic Req1,
    input  logic MemReady,
    output logic Selector,
    output logic MemReq,
    output logic Ack0,
    output logic Ack1,
    output logic Busy,
    output logic Error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   memreq_q, memreq_d;
    logic   ack0_q, ack0_d;
    logic   ack1_q, ack1_d;
    logic   last_q, last_d;
    logic   grant;

    if ((2 ** CNT_WIDTH) <= TIMEOUT_CYCLES) begin : g_cfg_check
        $error("arbitro_2a1: CNT_WIDTH too narrow for TIMEOUT_CYCLES");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
`endif

    // Tie goes to whoever was not served last; LastGrant resets to 1 so requester 0 wins first.
    assign grant = (Req0 && Req1) ? ~last_q : Req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            memreq_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            last_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            memreq_q <= memreq_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            last_q   <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        memreq_d = memreq_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    sel_d    = grant;
                    last_d   = grant;
                    memreq_d = 1'b1;
                    state_d  = ACTIVE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ACTIVE: begin
                if (MemReady) begin
                    memreq_d = 1'b0;
                    ack0_d   = ~sel_q;
                    ack1_d   = sel_q;
                    state_d  = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                // Abort on the edge that would bring the count to TIMEOUT_CYCLES.
                else if (cnt_q == TO_LAST) begin
                    memreq_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                memreq_d = 1'b0;
            end
        endcase
    end

    assign Selector = sel_q;
    assign MemReq   = memreq_q;
    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign Busy     = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
    assign Error    = err_q;
`else
    assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_2a1.sv
// Directed self-checking bench for arbitro_2a1; watchdog scenarios run when ARB_TIMEOUT_EN is defined.

module tb_arbitro_2a1;

    logic clk = 1'b0;
    logic reset, Req0, Req1, MemReady;
    logic Selector, MemReq, Ack0, Ack1, Busy, Error;
    int   checks = 0;
    int   errors = 0;

    arbitro_2a1 #(.TIMEOUT_CYCLES(15), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .Req0(Req0), .Req1(Req1), .MemReady(MemReady),
        .Selector(Selector), .MemReq(MemReq), .Ack0(Ack0), .Ack1(Ack1),
        .Busy(Busy), .Error(Error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; MemReady = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; MemReady = 1'b0;
        #1;
        checks++;
        if ({Selector, MemReq, Ack0, Ack1, Busy, Error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp %b", {Selector, MemReq, Ack0, Ack1, Busy, Error}, 6'b0);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        Req0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({Selector, MemReq, Ack0, Ack1, Busy} !== 5'b01001) begin
                errors++;
                $display("FAIL single_active cyc%0d: got sel,mreq,a0,a1,busy=%b exp %b", i, {Selector, MemReq, Ack0, Ack1, Busy}, 5'b01001);
            end
            if (i == 3) MemReady = 1'b1;
        end
        tick();
        checks++;
        if ({Selector, MemReq, Ack0, Ack1, Busy} !== 5'b00101) begin
            errors++;
            $display("FAIL single_ack: got sel,mreq,a0,a1,busy=%b exp %b", {Selector, MemReq, Ack0, Ack1, Busy}, 5'b00101);
        end
        Req0 = 1'b0; MemReady = 1'b0;
        tick();
        checks++;
        if ({MemReq, Ack0, Ack1, Busy} !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle: got mreq,a0,a1,busy=%b exp %b", {MemReq, Ack0, Ack1, Busy}, 4'b0000);
        end
    endtask

    task automatic test_alternate();
        logic g;
        apply_reset();
        Req0 = 1'b1; Req1 = 1'b1; MemReady = 1'b1;
        g = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if ({Selector, MemReq, Ack0, Ack1} !== {g, 3'b100}) begin
                errors++;
                $display("FAIL alt_grant t%0d: got sel,mreq,a0,a1=%b exp %b", t, {Selector, MemReq, Ack0, Ack1}, {g, 3'b100});
            end
            tick();
            checks++;
            if ({MemReq, Ack0, Ack1} !== {1'b0, ~g, g}) begin
                errors++;
                $display("FAIL alt_ack t%0d: got mreq,a0,a1=%b exp %b", t, {MemReq, Ack0, Ack1}, {1'b0, ~g, g});
            end
            if (g) Req1 = 1'b0; else Req0 = 1'b0;
            tick();
            checks++;
            if ({Ack0, Ack1, Busy} !== 3'b000) begin
                errors++;
                $display("FAIL alt_gap t%0d: got a0,a1,busy=%b exp %b", t, {Ack0, Ack1, Busy}, 3'b000);
            end
            Req0 = 1'b1; Req1 = 1'b1;
            g = ~g;
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick(); tick(); tick();
        MemReady = 1'b0;
    endtask

    task automatic test_selector_hold();
        apply_reset();
        Req1 = 1'b1; MemReady = 1'b1;
        tick();
        checks++;
        if ({Selector, MemReq} !== 2'b11) begin
            errors++;
            $display("FAIL hold_grant1: got sel,mreq=%b exp %b", {Selector, MemReq}, 2'b11);
        end
        tick();
        checks++;
        if ({Selector, Ack0, Ack1} !== 3'b101) begin
            errors++;
            $display("FAIL hold_ack1: got sel,a0,a1=%b exp %b", {Selector, Ack0, Ack1}, 3'b101);
        end
        Req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Selector, Busy} !== 2'b10) begin
                errors++;
                $display("FAIL hold_idle_sel c%0d: got sel,busy=%b exp %b", i, {Selector, Busy}, 2'b10);
            end
        end
        Req0 = 1'b1;
        tick();
        checks++;
        if ({Selector, MemReq} !== 2'b01) begin
            errors++;
            $display("FAIL hold_switch0: got sel,mreq=%b exp %b", {Selector, MemReq}, 2'b01);
        end
        tick();
        checks++;
        if ({Selector, Ack0, Ack1} !== 3'b010) begin
            errors++;
            $display("FAIL hold_ack0: got sel,a0,a1=%b exp %b", {Selector, Ack0, Ack1}, 3'b010);
        end
        Req0 = 1'b0; MemReady = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        Req1 = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({Selector, MemReq, Ack0, Ack1, Busy, Error} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: got %b exp %b", {Selector, MemReq, Ack0, Ack1, Busy, Error}, 6'b0);
        end
        Req1 = 1'b0; Req0 = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({MemReq, Ack0, Ack1, Busy} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_held: got mreq,a0,a1,busy=%b exp %b", {MemReq, Ack0, Ack1, Busy}, 4'b0);
        end
        tick();
        checks++;
        if ({Selector, MemReq, Ack0, Ack1, Busy} !== 5'b01001) begin
            errors++;
            $display("FAIL rst_mid_regrant: got sel,mreq,a0,a1,busy=%b exp %b", {Selector, MemReq, Ack0, Ack1, Busy}, 5'b01001);
        end
        MemReady = 1'b1;
        tick();
        checks++;
        if ({Ack0, Ack1} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_ack: got a0,a1=%b exp %b", {Ack0, Ack1}, 2'b10);
        end
        Req0 = 1'b0; MemReady = 1'b0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        Req0 = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if ({MemReq, Error} !== 2'b10) begin
                errors++;
                $display("FAIL to_wait k%0d: got mreq,err=%b exp %b", k, {MemReq, Error}, 2'b10);
            end
        end
        tick();
        checks++;
        if ({MemReq, Ack0, Ack1, Error, Busy} !== 5'b00011) begin
            errors++;
            $display("FAIL to_abort: got mreq,a0,a1,err,busy=%b exp %b", {MemReq, Ack0, Ack1, Error, Busy}, 5'b00011);
        end
        Req0 = 1'b0;
        tick();
        checks++;
        if ({Error, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL to_err_pulse: got err,busy=%b exp %b", {Error, Busy}, 2'b00);
        end
        Req0 = 1'b1; Req1 = 1'b1; MemReady = 1'b1;
        tick();
        checks++;
        if ({Selector, MemReq} !== 2'b11) begin
            errors++;
            $display("FAIL to_next_tie: got sel,mreq=%b exp %b", {Selector, MemReq}, 2'b11);
        end
        tick();
        Req0 = 1'b0; Req1 = 1'b0; MemReady = 1'b0;
        tick();
    endtask

    task automatic test_timeout_edge();
        apply_reset();
        Req0 = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        MemReady = 1'b1;
        tick();
        checks++;
        if ({MemReq, Ack0, Ack1, Error} !== 4'b0100) begin
            errors++;
            $display("FAIL to_edge_ready: got mreq,a0,a1,err=%b exp %b", {MemReq, Ack0, Ack1, Error}, 4'b0100);
        end
        Req0 = 1'b0; MemReady = 1'b0;
        tick();
        checks++;
        if (Error !== 1'b0) begin
            errors++;
            $display("FAIL to_edge_noerr: got %b exp %b", Error, 1'b0);
        end
    endtask
`else
    task automatic test_no_watchdog();
        apply_reset();
        Req0 = 1'b1;
        tick();
        Req0 = 1'b0;
        for (int k = 0; k < 24; k++) tick();
        checks++;
        if ({MemReq, Busy, Error, Ack0} !== 4'b1100) begin
            errors++;
            $display("FAIL nowd_wait: got mreq,busy,err,a0=%b exp %b", {MemReq, Busy, Error, Ack0}, 4'b1100);
        end
        MemReady = 1'b1;
        tick();
        checks++;
        if ({MemReq, Ack0, Error} !== 3'b010) begin
            errors++;
            $display("FAIL nowd_late_ack: got mreq,a0,err=%b exp %b", {MemReq, Ack0, Error}, 3'b010);
        end
        MemReady = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_selector_hold();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_edge();
`else
        test_no_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
